fb_sync_fifo: RTL and testbench
===============================

# fb_sync_fifo

Parametrised single-clock synchronous FIFO, the next generation of the team's basic FIFO. It adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, a fill-level count, sticky overflow/underflow error flags, and a selectable read mode: registered output or first-word fall-through. It is the standard buffering element between producer/consumer stages inside one clock domain.

## Interface
- DEPTH, 8: number of entries; legal range is 2 or more, and any integer is allowed.
- WIDTH, 32: data width in bits; 1 or more.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = registered read; 1 = first-word fall-through.
- clk  input  1  the single clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- push  input  1  write request.
- in  input  WIDTH  write data, sampled on an accepted push.
- pop  input  1  read request.
- clr_err  input  1  clears overflow and underflow.
- out  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky flag: a push was dropped.
- underflow  output  1  sticky flag: a pop was ignored.

## Operation
- Storage is a DEPTH×WIDTH array. The array is not reset.
- Write pointer and read pointer each run 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not by power-of-two truncation.
- Push acceptance: a push is accepted when push=1 and (full=0, or pop is accepted in the same cycle).
  - When full, a simultaneous push and pop are both accepted and count is unchanged.
- Pop acceptance: a pop is accepted when pop=1 and empty=0.
  - A pop while empty is ignored, even if a push is accepted in the same cycle. There is no bypass from in to out.
- Accepted push: mem[wr_ptr] <= in, and wr_ptr advances.
- Accepted pop: rd_ptr advances.
- Count update: +1 for push only, -1 for pop only, unchanged for both or neither. Count never leaves 0..DEPTH.
- full, empty, almost_full and almost_empty are decoded from the registered count only.
- overflow is set the cycle after push=1 while full=0 is false and no pop is accepted; the data is dropped and FIFO state is unchanged.
- underflow is set the cycle after pop=1 while empty=1.
- clr_err=1 clears both error flags. If clr_err and a new error occur in the same cycle, set wins.
- FWFT=0: out is a register. An accepted pop loads out <= mem[rd_ptr] on that edge. Otherwise out holds its last value.
- FWFT=1: out = mem[rd_ptr] combinationally while empty=0. When empty=1, out shows 0.
- Reset (rst_n=0 at an edge) applies to the following:
  - Pointers and count go to 0.
  - empty=1, full=0, almost_full=0, almost_empty=1.
  - overflow=0, underflow=0, out=0.
  - Reset overrides any push or pop in the same cycle.
  - Data in flight is discarded.

## Timing
- Push to visible: data pushed at edge N makes empty=0 after edge N. With FWFT=1, out is valid in cycle N+1.
- Pop latency, FWFT=0: pop accepted at edge N gives data on out after edge N (one cycle from request).
- Pop latency, FWFT=1: the head word is already on out when pop is asserted. After edge N, out shows the next entry.
- All flags and count change only on clock edges and reflect the operation accepted at that edge.
- Throughput: one push and one pop per cycle sustained, with no bubbles at full or at pointer wrap.
- Full to not-full: push is accepted in the cycle where full=1 and pop=1. Ignoring that case, full deasserts one edge after an accepted pop.

## Test plan
- Fill and drain (DEPTH=8, FWFT=0): push 0x0..0x7 on 8 consecutive cycles. full=1 and count=8 after the 8th edge. Pop 8 times; out gives 0x0..0x7 in order, each one cycle after its pop. empty=1 and count=0 at the end.
- Wrap, non-power-of-two depth (DEPTH=5, FWFT=1): keep push+pop streaming continuously for 20 cycles at count=3. Ordering is preserved across pointer wraps and count stays 3 throughout.
- Full boundary (DEPTH=4): fill to full, then push 0xAA with no pop. overflow=1, count stays 4, and 0xAA never appears on out. Then push 0xBB with pop in the same cycle: both accepted, count=4, and 0xBB is read last. clr_err=1 clears overflow.
- Empty boundary: pop on an empty FIFO sets underflow=1 with count=0. On an empty FIFO, push 0x5 with pop in the same cycle: push accepted, pop ignored, count=1, underflow set.
- Thresholds (DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=1):
  - almost_full rises after the 6th push and falls after the next pop.
  - almost_empty is 1 at count 0..1 and 0 at count 2.
- Reset mid-operation: at count=5 with overflow set, assert rst_n=0 for one cycle with push=1 asserted. All outputs return to their reset values and count=0. A subsequent push/pop returns the new data, not stale data.

Source files
------------

// File: rtl/fb_sync_fifo_if.sv
// Handshake and status bundle for fb_sync_fifo; master = producer/consumer side, slave = FIFO side.
// WIDTH and DEPTH must match the parameters of the attached fb_sync_fifo.
interface fb_sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] in;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, in, pop, clr_err,
    input  out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, in, pop, clr_err,
    output out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fb_sync_fifo.sv
// Single-clock FIFO, any DEPTH>=2; read latency 1 cycle (FWFT=0) or 0 (FWFT=1, head shown while non-empty).
// No backpressure stall: pushes when full (without a pop) are dropped and flagged, pops when empty are ignored and flagged.
module fb_sync_fifo #(
  parameter int DEPTH         = 8,
  parameter int WIDTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  fb_sync_fifo_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q, underflow_q;

  logic full, empty;
  logic do_push, do_pop;
  logic ovf_evt, udf_evt;

  // All status flags decode from the registered count only.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A pop frees the slot this same edge, so a push at full is still accepted.
  assign do_pop  = bus.pop && !empty;
  assign do_push = bus.push && (!full || do_pop);
  assign ovf_evt = bus.push && full && !do_pop;
  assign udf_evt = bus.pop && empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_ONE;
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_q  <= ovf_evt || (overflow_q && !bus.clr_err);
      underflow_q <= udf_evt || (underflow_q && !bus.clr_err);
    end
  end

  // Storage is not reset; writes are still blocked during reset so nothing in flight lands.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wr_ptr] <= bus.in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.out = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] out_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_q <= '0;
        end else if (do_pop) begin
          out_q <= mem[rd_ptr];
        end
      end
      assign bus.out = out_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fb_sync_fifo.sv
// Directed bench for fb_sync_fifo: three instances (depth 8 registered, depth 5 FWFT, depth 4 registered).
module tb_fb_sync_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fb_sync_fifo_if #(.WIDTH(32), .DEPTH(8)) f8 ();
  fb_sync_fifo_if #(.WIDTH(8),  .DEPTH(5)) f5 ();
  fb_sync_fifo_if #(.WIDTH(8),  .DEPTH(4)) f4 ();

  fb_sync_fifo #(.DEPTH(8), .WIDTH(32), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(0)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(f8.slave)
  );
  fb_sync_fifo #(.DEPTH(5), .WIDTH(8), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) u5 (
    .clk(clk), .rst_n(rst_n), .bus(f5.slave)
  );
  fb_sync_fifo #(.DEPTH(4), .WIDTH(8), .AFULL_THRESH(2), .AEMPTY_THRESH(1), .FWFT(0)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(f4.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    f8.push = 1'b0; f8.pop = 1'b0; f8.clr_err = 1'b0; f8.in = '0;
    f5.push = 1'b0; f5.pop = 1'b0; f5.clr_err = 1'b0; f5.in = '0;
    f4.push = 1'b0; f4.pop = 1'b0; f4.clr_err = 1'b0; f4.in = '0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_count",  32'(f8.count), 0);
    chk("rst_empty",  32'(f8.empty), 1);
    chk("rst_full",   32'(f8.full), 0);
    chk("rst_afull",  32'(f8.almost_full), 0);
    chk("rst_aempty", 32'(f8.almost_empty), 1);
    chk("rst_ovf",    32'(f8.overflow), 0);
    chk("rst_udf",    32'(f8.underflow), 0);
    chk("rst_out8",   f8.out, 0);
    chk("rst_out5",   32'(f5.out), 0);
    chk("rst_out4",   32'(f4.out), 0);

    // Fill depth 8 with thresholds checked at each level
    for (int i = 0; i < 8; i++) begin
      f8.push = 1'b1;
      f8.in   = i;
      step();
      chk("fill_count",  32'(f8.count), i + 1);
      chk("fill_afull",  32'(f8.almost_full), (i + 1 >= 6) ? 1 : 0);
      chk("fill_aempty", 32'(f8.almost_empty), (i + 1 <= 1) ? 1 : 0);
      chk("fill_full",   32'(f8.full), (i + 1 == 8) ? 1 : 0);
      chk("fill_empty",  32'(f8.empty), 0);
    end
    f8.push = 1'b0;

    // Drain: each word appears the edge its pop is accepted
    for (int j = 0; j < 8; j++) begin
      f8.pop = 1'b1;
      step();
      chk("drain_out",    f8.out, j);
      chk("drain_count",  32'(f8.count), 7 - j);
      chk("drain_afull",  32'(f8.almost_full), (7 - j >= 6) ? 1 : 0);
      chk("drain_aempty", 32'(f8.almost_empty), (7 - j <= 1) ? 1 : 0);
    end
    f8.pop = 1'b0;
    step();
    chk("drain_empty", 32'(f8.empty), 1);
    chk("out_holds",   f8.out, 7);

    // Empty boundary
    f8.pop = 1'b1;
    step();
    chk("udf_set",       32'(f8.underflow), 1);
    chk("udf_count",     32'(f8.count), 0);
    f8.clr_err = 1'b1;
    step();
    chk("udf_set_wins",  32'(f8.underflow), 1);
    f8.pop = 1'b0;
    step();
    chk("udf_clr",       32'(f8.underflow), 0);
    f8.clr_err = 1'b0;
    f8.push = 1'b1; f8.in = 32'h5; f8.pop = 1'b1;
    step();
    chk("pe_count",      32'(f8.count), 1);
    chk("pe_udf",        32'(f8.underflow), 1);
    chk("pe_no_bypass",  f8.out, 7);
    f8.push = 1'b0;
    step();
    chk("pe_pop_out",    f8.out, 5);
    chk("pe_pop_count",  32'(f8.count), 0);
    f8.pop = 1'b0;
    f8.clr_err = 1'b1;
    step();
    f8.clr_err = 1'b0;
    chk("pe_udf_clr",    32'(f8.underflow), 0);

    // FWFT streaming across wraps at depth 5
    chk("fwft_empty_out", 32'(f5.out), 0);
    for (int i = 0; i < 3; i++) begin
      f5.push = 1'b1;
      f5.in   = 8'(100 + i);
      step();
    end
    chk("fwft_head", 32'(f5.out), 100);
    chk("fwft_cnt3", 32'(f5.count), 3);
    for (int k = 0; k < 20; k++) begin
      chk("stream_out", 32'(f5.out), 100 + k);
      f5.push = 1'b1;
      f5.in   = 8'(103 + k);
      f5.pop  = 1'b1;
      step();
      chk("stream_count", 32'(f5.count), 3);
    end
    f5.push = 1'b0;
    f5.pop  = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("fwft_drain_out", 32'(f5.out), 120 + j);
      f5.pop = 1'b1;
      step();
    end
    f5.pop = 1'b0;
    chk("fwft_end_empty", 32'(f5.empty), 1);
    chk("fwft_end_out",   32'(f5.out), 0);

    // Full boundary at depth 4
    for (int i = 0; i < 4; i++) begin
      f4.push = 1'b1;
      f4.in   = 8'(8'h10 + i);
      step();
    end
    chk("f4_full",  32'(f4.full), 1);
    chk("f4_count", 32'(f4.count), 4);
    f4.in = 8'hAA;
    step();
    chk("ovf_set",   32'(f4.overflow), 1);
    chk("ovf_count", 32'(f4.count), 4);
    f4.in  = 8'hBB;
    f4.pop = 1'b1;
    step();
    chk("fullpp_count", 32'(f4.count), 4);
    chk("fullpp_out",   32'(f4.out), 32'h10);
    chk("fullpp_ovf",   32'(f4.overflow), 1);
    f4.push = 1'b0;
    f4.pop  = 1'b0;
    f4.clr_err = 1'b1;
    step();
    chk("ovf_clr", 32'(f4.overflow), 0);
    f4.push = 1'b1;
    f4.in   = 8'hCC;
    step();
    chk("ovf_set_wins", 32'(f4.overflow), 1);
    chk("ovf_cnt_keep", 32'(f4.count), 4);
    f4.push = 1'b0;
    step();
    chk("ovf_clr2", 32'(f4.overflow), 0);
    f4.clr_err = 1'b0;
    f4.pop = 1'b1;
    step();
    chk("f4_d0", 32'(f4.out), 32'h11);
    step();
    chk("f4_d1", 32'(f4.out), 32'h12);
    step();
    chk("f4_d2", 32'(f4.out), 32'h13);
    step();
    chk("f4_d3", 32'(f4.out), 32'hBB);
    f4.pop = 1'b0;
    chk("f4_empty", 32'(f4.empty), 1);
    chk("f4_udf",   32'(f4.underflow), 0);

    // Reset mid-operation: count 5, overflow set, push asserted during reset
    for (int i = 0; i < 9; i++) begin
      f8.push = 1'b1;
      f8.in   = 32'h20 + i;
      step();
    end
    f8.push = 1'b0;
    f8.pop  = 1'b1;
    step();
    step();
    step();
    f8.pop = 1'b0;
    chk("pre_rst_count", 32'(f8.count), 5);
    chk("pre_rst_ovf",   32'(f8.overflow), 1);
    chk("pre_rst_out",   f8.out, 32'h22);
    rst_n   = 1'b0;
    f8.push = 1'b1;
    f8.in   = 32'hEE;
    step();
    rst_n   = 1'b1;
    f8.push = 1'b0;
    chk("mrst_count",  32'(f8.count), 0);
    chk("mrst_empty",  32'(f8.empty), 1);
    chk("mrst_full",   32'(f8.full), 0);
    chk("mrst_afull",  32'(f8.almost_full), 0);
    chk("mrst_aempty", 32'(f8.almost_empty), 1);
    chk("mrst_ovf",    32'(f8.overflow), 0);
    chk("mrst_udf",    32'(f8.underflow), 0);
    chk("mrst_out",    f8.out, 0);
    f8.push = 1'b1;
    f8.in   = 32'h77;
    step();
    f8.push = 1'b0;
    chk("post_rst_count", 32'(f8.count), 1);
    f8.pop = 1'b1;
    step();
    f8.pop = 1'b0;
    chk("post_rst_out",   f8.out, 32'h77);
    chk("post_rst_empty", 32'(f8.empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
